// File: rtl/timer_sequencer.sv
// Timer sequencer: runs a 4-deep queue of presets through the timer device.
// Ports: clk, reset (async low), CPU bus Addr/WE/DataIn/DataOut, timer bus T_*, IRQ.
module timer_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic [31:0] T_Addr,
  output logic        T_WE,
  output logic [31:0] T_DataIn,
  input  logic [31:0] T_DataOut,
  input  logic        T_IRQ,
  output logic        IRQ
);

  localparam logic [31:0] A_CTRL   = 32'h0000_7f20;
  localparam logic [31:0] A_QUEUE  = 32'h0000_7f24;
  localparam logic [31:0] A_STATUS = 32'h0000_7f28;
  localparam logic [31:0] A_LIVE   = 32'h0000_7f2c;
  localparam logic [31:0] T_CTRL   = 32'h0000_7f10;
  localparam logic [31:0] T_PRESET = 32'h0000_7f14;
  localparam logic [31:0] T_COUNT  = 32'h0000_7f18;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_WR_PRE, S_WR_CTL, S_WAIT, S_DISARM
  } state_t;

  state_t      state;
  logic [31:0] fifo [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  cnt;
  logic [31:0] cur;
  logic        run;
  logic        loop;
  logic        ie;
  logic        done;
  logic        ovf;
  logic        fin;

  logic        wr_ctrl;
  logic        wr_queue;
  logic        wr_status;
  logic        pop;
  logic        repush;
  logic        rp_ok;
  logic        cpu_ok;
  logic        ovf_set;
  logic        done_set;
  logic [2:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [1:0]  cpu_slot;
  logic        busy;

  assign wr_ctrl   = WE && (Addr == A_CTRL);
  assign wr_queue  = WE && (Addr == A_QUEUE);
  assign wr_status = WE && (Addr == A_STATUS);
  assign busy      = (state != S_IDLE);

  // Occupancy is resolved in order: pop, then re-push, then CPU push.
  // Each push only lands if the running count has a free slot.
  assign pop      = (state == S_POP);
  assign repush   = (state == S_DISARM) && fin && loop;
  assign done_set = (state == S_DISARM) && fin;
  assign cnt_a    = cnt - {2'b0, pop};
  assign rp_ok    = repush && (cnt_a != 3'd4);
  assign cnt_b    = cnt_a + {2'b0, rp_ok};
  assign cpu_ok   = wr_queue && (cnt_b != 3'd4);
  assign ovf_set  = (repush && !rp_ok) || (wr_queue && !cpu_ok);
  assign cpu_slot = wr_ptr + {1'b0, rp_ok};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cur    <= '0;
      run    <= 1'b0;
      loop   <= 1'b0;
      ie     <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      fin    <= 1'b0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      if (wr_ctrl) {ie, loop, run} <= DataIn[2:0];
      // Set beats a same-cycle CPU clear.
      if (ovf_set) ovf <= 1'b1;
      else if (wr_status) ovf <= 1'b0;
      if (done_set) done <= 1'b1;
      else if (wr_status) done <= 1'b0;
      if (rp_ok) fifo[wr_ptr] <= cur;
      if (cpu_ok) fifo[cpu_slot] <= DataIn;
      rd_ptr <= rd_ptr + {1'b0, pop};
      wr_ptr <= wr_ptr + {1'b0, rp_ok} + {1'b0, cpu_ok};
      cnt    <= cnt_b + {2'b0, cpu_ok};
      unique case (state)
        S_IDLE:   if (run && cnt != 3'd0) state <= S_POP;
        S_POP: begin
          cur   <= fifo[rd_ptr];
          state <= S_WR_PRE;
        end
        S_WR_PRE: state <= S_WR_CTL;
        S_WR_CTL: state <= S_WAIT;
        S_WAIT: begin
          if (T_IRQ) begin
            fin   <= 1'b1;
            state <= S_DISARM;
          end else if (!run) begin
            fin   <= 1'b0;
            state <= S_DISARM;
          end
        end
        S_DISARM: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    T_WE     = 1'b0;
    T_Addr   = T_COUNT;
    T_DataIn = '0;
    unique case (state)
      S_WR_PRE: begin
        T_WE     = 1'b1;
        T_Addr   = T_PRESET;
        T_DataIn = cur;
      end
      S_WR_CTL: begin
        T_WE     = 1'b1;
        T_Addr   = T_CTRL;
        T_DataIn = 32'h0000_0009;
      end
      S_DISARM: begin
        T_WE     = 1'b1;
        T_Addr   = T_CTRL;
      end
      default: ;
    endcase
  end

  always_comb begin
    DataOut = '0;
    unique case (1'b1)
      (Addr == A_CTRL):   DataOut = {29'b0, ie, loop, run};
      (Addr == A_STATUS): DataOut = {24'b0, ovf, done, busy, 2'b0, cnt};
      (Addr == A_LIVE):   DataOut = T_DataOut;
      default:            DataOut = '0;
    endcase
  end

  assign IRQ = done & ie;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: random presets vs a queue-level model,
// timer bus writes checked by a scoreboard monitor.
module tb_timer_sequencer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7f20;
  localparam logic [31:0] A_QUEUE  = 32'h0000_7f24;
  localparam logic [31:0] A_STATUS = 32'h0000_7f28;
  localparam logic [31:0] A_LIVE   = 32'h0000_7f2c;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [31:0] T_Addr;
  logic        T_WE;
  logic [31:0] T_DataIn;
  logic [31:0] T_DataOut;
  logic        T_IRQ;
  logic        IRQ;

  always #5 clk = ~clk;

  timer_sequencer dut (
    .clk(clk), .reset(reset),
    .Addr(Addr), .WE(WE), .DataIn(DataIn), .DataOut(DataOut),
    .T_Addr(T_Addr), .T_WE(T_WE), .T_DataIn(T_DataIn),
    .T_DataOut(T_DataOut), .T_IRQ(T_IRQ), .IRQ(IRQ)
  );

  int vectors = 0;
  int miscompares = 0;
  int ctl_cnt = 0;
  logic [63:0] exp_q[$];

  // Reference model: a plain queue of presets plus flags.
  int unsigned mq[$];
  bit m_done, m_ovf, m_loop, m_ie;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input bit busy);
    logic [2:0] c;
    c = 3'(mq.size());
    return {24'b0, m_ovf, m_done, busy, 2'b0, c};
  endfunction

  task automatic m_push(input int unsigned v);
    if (mq.size() < 4) mq.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; DataIn = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; Addr = 32'h0;
  endtask

  task automatic cpu_push(input int unsigned v);
    cpu_wr(A_QUEUE, v);
    m_push(v);
  endtask

  task automatic cpu_rd_chk(input logic [31:0] a, input logic [31:0] e,
                            input string name);
    @(negedge clk);
    Addr = a; WE = 1'b0;
    #1;
    check(name, DataOut, e);
  endtask

  task automatic wait_ctl(input int c0);
    int n = 0;
    while (ctl_cnt == c0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ctl_cnt == c0) begin
      miscompares++;
      $display("FAIL ctl_timeout: got no ctrl write, expected one");
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_done = 0; m_ovf = 0; m_loop = 0; m_ie = 0;
  endtask

  // Scoreboard monitor for the timer bus.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (T_WE) begin
        if (T_Addr == 32'h7f10 && T_DataIn == 32'h9) ctl_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL twrite: got unexpected %h/%h expected none",
                   T_Addr, T_DataIn);
        end else begin
          check("twrite", {T_Addr, T_DataIn}, exp_q.pop_front());
        end
      end else begin
        check("tidle", {T_Addr, T_DataIn}, {32'h7f18, 32'h0});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned v, y;
    int c0, n;
    reset = 1'b0; WE = 1'b0; Addr = A_CTRL; DataIn = '0;
    T_IRQ = 1'b0; T_DataOut = $urandom;
    model_clear();

    #2;
    check("rst_twe", T_WE, 1'b0);
    check("rst_taddr", T_Addr, 32'h7f18);
    check("rst_tdata", T_DataIn, 32'h0);
    check("rst_irq", IRQ, 1'b0);
    check("rst_ctrl", DataOut, 32'h0);
    Addr = A_STATUS; #1;
    check("rst_status", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Overflow with the sequencer stopped.
    for (int i = 0; i < 5; i++) cpu_push($urandom_range(1, 50000));
    cpu_rd_chk(A_STATUS, status_exp(0), "status_ovf");
    cpu_rd_chk(A_STATUS, 32'h84, "status_ovf_lit");
    cpu_wr(A_STATUS, 32'h0);
    m_ovf = 0;
    cpu_rd_chk(A_STATUS, status_exp(0), "status_clr");
    cpu_rd_chk(A_QUEUE, 32'h0, "queue_rd");
    cpu_rd_chk(32'h7f30, 32'h0, "unmapped_rd");
    cpu_rd_chk(A_LIVE, T_DataOut, "live_rd");

    // Random run: presets, re-push, aborts, clears, CTRL rewrites.
    m_loop = 1'($urandom_range(0, 1));
    m_ie = 1'b1;
    cpu_wr(A_CTRL, {29'b0, m_ie, m_loop, 1'b1});
    cpu_rd_chk(A_CTRL, {29'b0, m_ie, m_loop, 1'b1}, "ctrl_rd");
    for (int r = 0; r < 30; r++) begin
      c0 = ctl_cnt;
      if (mq.size() == 0) cpu_push($urandom_range(1, 50000));
      v = mq.pop_front();
      exp_q.push_back({32'h7f14, v});
      exp_q.push_back({32'h7f10, 32'h9});
      wait_ctl(c0);
      if ($urandom_range(0, 3) == 0) cpu_push($urandom_range(1, 50000));
      if ($urandom_range(0, 4) == 0) begin
        cpu_wr(A_STATUS, 32'h0);
        m_done = 0; m_ovf = 0;
      end
      if ($urandom_range(0, 6) == 0) begin
        m_loop = 1'($urandom_range(0, 1));
        m_ie = 1'($urandom_range(0, 1));
        cpu_wr(A_CTRL, {29'b0, m_ie, m_loop, 1'b1});
      end
      cpu_rd_chk(A_STATUS, status_exp(1), "status_wait");
      check("irq_wait", IRQ, m_done & m_ie);
      if ($urandom_range(0, 5) == 0) begin
        exp_q.push_back({32'h7f10, 32'h0});
        cpu_wr(A_CTRL, {29'b0, m_ie, m_loop, 1'b0});
        repeat (3) @(negedge clk);
        cpu_rd_chk(A_STATUS, status_exp(0), "status_abort");
        cpu_wr(A_CTRL, {29'b0, m_ie, m_loop, 1'b1});
      end else begin
        exp_q.push_back({32'h7f10, 32'h0});
        @(negedge clk); T_IRQ = 1'b1;
        @(negedge clk); T_IRQ = 1'b0;
        m_done = 1;
        if (m_loop) m_push(v);
        @(negedge clk);
        check("irq_done", IRQ, m_done & m_ie);
      end
    end
    reset = 1'b0;
    #2;
    check("drain_b", exp_q.size(), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Full queue, loop on, CPU push lands on the DISARM cycle.
    for (int i = 0; i < 4; i++) cpu_push($urandom_range(1, 50000));
    m_loop = 1;
    c0 = ctl_cnt;
    cpu_wr(A_CTRL, 32'h3);
    v = mq.pop_front();
    exp_q.push_back({32'h7f14, v});
    exp_q.push_back({32'h7f10, 32'h9});
    wait_ctl(c0);
    cpu_push($urandom_range(1, 50000));
    cpu_rd_chk(A_STATUS, status_exp(1), "status_full_wait");
    exp_q.push_back({32'h7f10, 32'h0});
    y = $urandom_range(1, 50000);
    @(negedge clk); T_IRQ = 1'b1;
    @(negedge clk); T_IRQ = 1'b0;
    Addr = A_QUEUE; DataIn = y; WE = 1'b1;
    m_done = 1;
    m_push(v);
    m_push(y);
    @(negedge clk);
    WE = 1'b0; Addr = A_STATUS;
    #1;
    check("status_collide", DataOut, status_exp(0));
    check("status_collide_lit", DataOut, 32'hc4);
    reset = 1'b0;
    #2;
    check("drain_c", exp_q.size(), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Reset during the timer CTRL write.
    cpu_push(77);
    cpu_wr(A_CTRL, 32'h1);
    exp_q.push_back({32'h7f14, 32'd77});
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(T_WE && T_Addr == 32'h7f14) && n < 20);
    check("pre_seen", {T_WE, T_Addr}, {1'b1, 32'h7f14});
    @(posedge clk); #1;
    check("in_wr_ctl", {T_WE, T_Addr, T_DataIn}, {1'b1, 32'h7f10, 32'h9});
    reset = 1'b0;
    #1;
    check("rst_mid_twe", T_WE, 1'b0);
    check("rst_mid_taddr", T_Addr, 32'h7f18);
    Addr = A_CTRL; #1;
    check("rst_mid_ctrl", DataOut, 32'h0);
    Addr = A_STATUS; #1;
    check("rst_mid_status", DataOut, 32'h0);
    check("rst_mid_irq", IRQ, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("drain_d", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-003 SHALL have ports Addr (input, 32), WE (input, 1), DataIn (input, 32), DataOut (output, 32): CPU-side register bus, base 0x0000_7f20.
REQ-004 SHALL have ports T_Addr (output, 32), T_WE (output, 1), T_DataIn (output, 32): master-side bus to the timer device (CTRL 0x7f10, PRESET 0x7f14, COUNT 0x7f18).
REQ-005 SHALL have ports T_DataOut (input, 32), the timer read data, and T_IRQ (input, 1), the timer interrupt.
REQ-006 SHALL have port IRQ, output, 1 bit: sequencer interrupt to CP0.

Function
REQ-007 SHALL decode CPU registers on full Addr: 0x7f20 CTRL {29'b0, IE, LOOP, RUN} (R/W); 0x7f24 QUEUE (write pushes DataIn, reads 0); 0x7f28 STATUS (R; any write clears DONE and OVF); 0x7f2C LIVE (R, returns T_DataOut).
REQ-008 SHALL return STATUS as {24'b0, OVF, DONE, BUSY, 2'b0, CNT[2:0]}; BUSY=1 when FSM is not IDLE; CNT = queue occupancy 0..4.
REQ-009 SHALL make DataOut combinational from Addr; unmapped addresses read 0; CPU writes take effect on the clock edge with WE=1.
REQ-010 SHALL hold a 4-entry FIFO of 32-bit presets; a push while CNT=4 is dropped and sets OVF (sticky).
REQ-011 SHALL implement FSM IDLE, POP, WR_PRE, WR_CTL, WAIT, DISARM, one state per cycle except WAIT.
REQ-012 IDLE: RUN=1 and CNT>0 -> POP; otherwise stay.
REQ-013 POP: dequeue head into CUR (CNT-1) -> WR_PRE.
REQ-014 WR_PRE: drive T_Addr=0x7f14, T_WE=1, T_DataIn=CUR -> WR_CTL.
REQ-015 WR_CTL: drive T_Addr=0x7f10, T_WE=1, T_DataIn=0x0000_0009 (IM=1, Mode=00, Enable=1) -> WAIT.
REQ-016 WAIT: T_IRQ=1 -> DISARM with FIN=1; RUN=0 (abort) -> DISARM with FIN=0; else stay.
REQ-017 DISARM: drive T_Addr=0x7f10, T_WE=1, T_DataIn=0 -> IDLE; if FIN=1 set DONE; if FIN=1 and LOOP=1 re-push CUR to FIFO tail.
REQ-018 In all states other than WR_PRE/WR_CTL/DISARM SHALL drive T_WE=0, T_Addr=0x7f18, T_DataIn=0.
REQ-019 Same-cycle re-push and CPU push: re-push written first, CPU push second; whichever finds CNT=4 is dropped and sets OVF.
REQ-020 Same-cycle POP and CPU push: both honoured; CNT unchanged when CNT was 4 (push accepted since a slot frees).
REQ-021 Abort (RUN cleared) SHALL discard CUR, not set DONE, not re-push; FIFO contents retained.
REQ-022 SHALL drive IRQ = DONE & IE, combinational from registers.
REQ-023 A CPU write clearing DONE in the same cycle DISARM sets it SHALL leave DONE=1 (set wins).
REQ-024 Writing CTRL with RUN=1 while BUSY SHALL not restart the current preset.

Reset
REQ-025 On reset=0: FSM=IDLE, CNT=0, FIFO pointers=0, CUR=0, RUN=LOOP=IE=0, DONE=OVF=0, FIN=0.
REQ-026 During reset: T_WE=0, T_Addr=0x0000_7f18, T_DataIn=0, IRQ=0; DataOut still decodes from registers (all zero).
REQ-027 Reset asserted mid-sequence (any state) SHALL abandon it with no further timer write; the timer is reset by its own reset.
REQ-028 After reset release, first state change SHALL occur no earlier than the next rising clk edge.

Verification
REQ-029 Push 5, write CTRL=0x5 -> T_WE pulses: 0x7f14/5 then 0x7f10/9 on consecutive cycles; after T_IRQ, 0x7f10/0 write, STATUS DONE=1, IRQ=1.
REQ-030 Push 3,7 with LOOP=1, RUN=1 -> presets written in order 3,7,3,7...; CNT stays 1 while in WAIT.
REQ-031 Push 5 values with RUN=0 -> CNT=4, OVF=1, STATUS=0x84; write 0x7f28 -> STATUS=0x04.
REQ-032 RUN=1 with preset 100, clear RUN during WAIT -> one 0x7f10/0 write, DONE=0, CNT unchanged, FSM IDLE.
REQ-033 Pull reset low during WR_CTL -> T_WE=0 immediately (before next edge), all STATUS/CTRL read 0.
REQ-034 CNT=4, LOOP=1, CPU push coincident with DISARM (FIN=1) -> re-push dropped, CPU push dropped, OVF=1, DONE=1.
